// File: rtl/red_iterativa_izq_der.sv
// Unsigned magnitude comparator: MSB-to-LSB iterative cell chain, registered flag Zout = (A <= B).
// Each cell keeps a decided GT/LT state and resolves EQ from its own bit pair.

module red_iterativa_izq_der_celda (
    input  logic       i_a,
    input  logic       i_b,
    input  logic [1:0] i_estado,
    output logic [1:0] o_estado
);

    typedef enum logic [1:0] {
        EQ = 2'b00,
        LT = 2'b01,
        GT = 2'b10
    } cmp_state_t;

    always_comb begin
        o_estado = i_estado;
        if (i_estado == EQ) begin
            if (i_a && !i_b) begin
                o_estado = GT;
            end else if (!i_a && i_b) begin
                o_estado = LT;
            end
        end
    end

endmodule

module red_iterativa_izq_der #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         Zout
);

    // w_estado[i+1] feeds cell i; w_estado[N] is the EQ seed at the MSB.
    logic [1:0] w_estado [N:0];
    logic       w_z_next;
    logic       r_zout;

    assign w_estado[N] = '0;

    for (genvar gi = 0; gi < N; gi++) begin : g_celda
        red_iterativa_izq_der_celda u_celda (
            .i_a      (A[gi]),
            .i_b      (B[gi]),
            .i_estado (w_estado[gi+1]),
            .o_estado (w_estado[gi])
        );
    end

    // EQ and LT both mean A <= B; only GT clears the flag.
    assign w_z_next = ~w_estado[0][1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zout <= 1'b1;
        end else begin
            r_zout <= w_z_next;
        end
    end

    assign Zout = r_zout;

endmodule

// File: tb/tb_red_iterativa_izq_der.sv
// Self-checking bench for red_iterativa_izq_der (N=3): directed corners, exhaustive sweep,
// alternating operands, async reset and randomized pairs against an arithmetic A <= B model.

module tb_red_iterativa_izq_der;

    localparam int unsigned N = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         Zout;

    int unsigned n_checks;
    int unsigned n_fail;

    red_iterativa_izq_der #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Zout (Zout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic observed, input logic expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic model_le(input int unsigned a, input int unsigned b);
        return (a <= b) ? 1'b1 : 1'b0;
    endfunction

    // Drive a pair mid-cycle, then check right after the sampling edge.
    task automatic apply(input string tag, input int unsigned a, input int unsigned b);
        @(negedge clk);
        A = a[N-1:0];
        B = b[N-1:0];
        @(posedge clk);
        #1;
        check(tag, Zout, model_le(a, b));
    endtask

    initial begin
        logic held;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        A   = 3'b111;
        B   = 3'b000;

        #3;
        rst = 1'b1;
        #1;
        check("rst_async_assert", Zout, 1'b1);
        @(posedge clk);
        #1;
        check("rst_held", Zout, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_first_edge", Zout, 1'b0);

        apply("eq_ones",  3'b111, 3'b111);
        apply("gt_max",   3'b111, 3'b000);
        apply("lt_max",   3'b000, 3'b111);
        apply("eq_zeros", 3'b000, 3'b000);
        apply("msb_gt",   3'b100, 3'b011);
        apply("msb_lt",   3'b011, 3'b100);
        apply("lsb_gt",   3'b101, 3'b100);
        apply("lsb_lt",   3'b100, 3'b101);

        for (int unsigned a = 0; a < 8; a++) begin
            for (int unsigned b = 0; b < 8; b++) begin
                apply("sweep", a, b);
            end
        end

        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) apply("alt_gt", 3'b110, 3'b010);
            else            apply("alt_le", 3'b010, 3'b110);
        end

        // Operand changes between edges must not reach Zout before the next edge.
        apply("hold_pre", 3'b001, 3'b110);
        held = Zout;
        A = 3'b111;
        B = 3'b000;
        #5;
        check("hold_between_edges", Zout, 1'b1);
        @(posedge clk);
        #1;
        check("hold_next_edge", Zout, 1'b0);

        // Reset mid-operation forces 1 at once and discards the pending result.
        apply("midrst_pre", 3'b110, 3'b001);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_async", Zout, 1'b1);
        @(posedge clk);
        #1;
        check("midrst_held", Zout, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        A = 3'b011;
        B = 3'b010;
        @(posedge clk);
        #1;
        check("midrst_release", Zout, 1'b0);

        for (int k = 0; k < 200; k++) begin
            apply("rand", $urandom_range(0, 7), $urandom_range(0, 7));
        end

        if (held !== 1'b1) begin
            check("hold_pre_value", held, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/red_iterativa_izq_der.md
# red_iterativa_izq_der

Unsigned magnitude comparator built as an iterative cell network. The network scans two N-bit words A and B from the most significant bit to the least significant bit. It asserts `Zout` when A ≤ B and deasserts it when A > B. It is a leaf datapath block: its inputs are driven from upstream logic and `Zout` is consumed as a registered condition flag.

## Interface
Parameters:
- `N`, default 3 — width of words A and B; legal range N ≥ 1.

Ports:
- `clk`  input  1  — system clock; all state changes on the rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `A`  input  N  — unsigned operand A; bit N-1 is the MSB.
- `B`  input  N  — unsigned operand B; bit N-1 is the MSB.
- `Zout`  output  1  — registered result: 1 when A ≤ B, 0 when A > B.

## Operation
- The network is a chain of N identical cells, indexed i = N-1 (MSB) down to 0 (LSB).
- Each cell takes one bit pair (A[i], B[i]) and a 2-bit incoming state, and produces a 2-bit outgoing state.
- State encoding:
  - EQ = 00: all bits so far are equal.
  - GT = 10: A > B is already decided.
  - LT = 01: A < B is already decided.
  - 11 is illegal and is never produced.
- The MSB cell receives EQ as its incoming state.
- Cell rule:
  - Incoming state GT or LT: the cell passes that state through unchanged.
  - Incoming state EQ and A[i]=1, B[i]=0: the cell outputs GT.
  - Incoming state EQ and A[i]=0, B[i]=1: the cell outputs LT.
  - Incoming state EQ and A[i]=B[i]: the cell outputs EQ.
- Combinational result `z_next` = NOT GT at the LSB cell output, so both EQ and LT give 1.
- Result semantics:
  - Equality (including all-zeros and all-ones) gives `Zout`=1.
  - Only strict A > B gives `Zout`=0.
- Operands are unsigned; there is no sign handling and no overflow concept.
- The cell is its own submodule. The chain is built with a generate loop so any legal N elaborates without edits.

## Timing
- The cell chain is purely combinational; its depth is N cells with no internal registers.
- `Zout` is a single flip-flop loaded with `z_next` on every rising `clk` edge.
- Latency: the operands present at rising edge k (setup/hold met) determine `Zout` immediately after edge k. `Zout` is valid for the whole following cycle.
- The circuit accepts new operands every cycle.
- Reset:
  - While `rst`=1, `Zout` is forced to 1 asynchronously, independent of `clk`. This matches the A=B=0 result.
  - After `rst` is released, the first rising edge loads the current comparison result.
- Reset asserted mid-operation: `Zout` goes to 1 immediately. Any pending comparison is discarded.
- The design has no handshake, no enable and no state machine beyond the result register.
- Operand changes between clock edges do not affect `Zout` until the next rising edge.

## Test plan
All scenarios use N=3 and a clock period of 20 ns. Checks are made after the sampling edge.
- Reset: assert `rst` with A=111, B=000 → `Zout`=1 while reset is held. First edge after release → `Zout`=0.
- Corner cases:
  - A=111, B=111 → 1.
  - A=111, B=000 → 0.
  - A=000, B=111 → 1.
  - A=000, B=000 → 1.
- MSB dominance: A=100, B=011 → 0. A=011, B=100 → 1. Confirms that the first differing bit from the left decides the result.
- LSB decision: A=101, B=100 → 0. A=100, B=101 → 1. Confirms that the EQ state propagates through the upper cells.
- Exhaustive sweep: all 64 (A,B) pairs, one per cycle → `Zout` equals (A ≤ B) one edge after each pair is applied, with zero mismatches.
- Back-to-back changes: alternate A=110/B=010 and A=010/B=110 every cycle → `Zout` toggles 0,1,0,1 with one-cycle latency.
